asl_result_stabilizer: RTL and testbench
========================================

// Module: asl_result_stabilizer
// PURPOSE
//  Downstream consumer of the ASL recognizer's per-frame classification stream (result_data_valid/result_data[4:0]).
//  Debounces the noisy per-frame labels into stable letter events.
//  - A label is emitted only after STABLE_CNT consecutive identical results.
//  - A letter is not re-emitted while the same sign is held.
//  - Emitted letters are buffered in a small FIFO with valid/ready output for the CPU/UART side.
// PARAMETERS
//  NUM_CLASSES   26  labels 0..NUM_CLASSES-1 are letters; labels >= NUM_CLASSES are "blank" (no sign)
//  STABLE_CNT    4   consecutive identical letter samples needed to emit; legal range 2..15
//  FIFO_DEPTH    4   output FIFO entries, power of 2, >= 2
//  IDLE_TIMEOUT  16000000  clk cycles without in_valid before the history is cleared; >= 2
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  asynchronous active-low reset
//  clear       in   1  synchronous soft clear
//  in_valid    in   1  one-cycle strobe, new classification result; no backpressure
//  in_label    in   5  classification result, sampled when in_valid=1
//  out_valid   out  1  FIFO head holds a stable letter
//  out_ready   in   1  consumer accepts head when out_valid & out_ready
//  out_label   out  5  FIFO head letter; forced to 0 when out_valid=0
//  fifo_level  out  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries
//  overflow    out  1  one-cycle pulse: a stable letter was dropped because the FIFO was full
// BEHAVIOUR
//  Reset: all registers clear; out_valid=0, out_label=0, fifo_level=0, overflow=0.
//   Internal state after reset: cand=0, streak=0, last_vld=0, idle_cnt=0.
//  State: cand[4:0], streak (0..STABLE_CNT, saturating), last_emit[4:0], last_vld, idle_cnt.
//  On in_valid=1 at a rising edge:
//   - in_label >= NUM_CLASSES (blank): streak<=0, last_vld<=0.
//   - in_label == cand and streak != 0: streak<=min(streak+1, STABLE_CNT).
//   - otherwise: cand<=in_label, streak<=1.
//  Qualify: in_valid & letter & label==cand & streak==STABLE_CNT-1 & !(last_vld & last_emit==cand).
//   On qualify: push cand into the FIFO at the same edge; last_emit<=cand; last_vld<=1.
//   Streak already at STABLE_CNT does not re-qualify.
//  Latency: out_valid rises the cycle after the qualifying sample's edge, provided the FIFO was empty.
//  FIFO:
//   - Pop occurs on out_valid & out_ready.
//   - Push and pop in the same cycle are allowed at any level. When full, the pop frees the slot and the push succeeds with no overflow.
//   - Push while full with no pop: letter dropped, overflow=1 for one cycle, last_emit/last_vld still update.
//   - Pointers wrap modulo FIFO_DEPTH.
//   - fifo_level is the registered count after each edge.
//  Idle timer:
//   - idle_cnt<=0 on any in_valid; otherwise increments, saturating at IDLE_TIMEOUT.
//   - In the cycle idle_cnt reaches IDLE_TIMEOUT: streak<=0, last_vld<=0, so a held-then-repeated letter (e.g. "LL") can be emitted again.
//   - FIFO is untouched by the timeout.
//  clear=1 (priority over in_valid and over the FIFO handshake in that cycle):
//   - Resets streak, last_vld, idle_cnt, FIFO pointers/level and overflow.
//   - A pop in that cycle is not counted.
//  No combinational path from in_valid/in_label to outputs; out_valid/out_label depend only on registers.
// TESTING (defaults unless stated; out_ready=1 unless stated)
//  1. 7,7,7,7,7,7 -> one out 7, out_valid high the cycle after the 4th sample; samples 5-6 produce nothing.
//  2. 7,7,7,3,7,7,7,7 -> exactly one out 7, after the 8th sample; 3 never emitted.
//  3. 7x4, 31, 7x4 -> outputs 7 then 7 (blank re-arms the same letter).
//  4. out_ready=0; labels 1,2,3,4,5 each x4 -> fifo_level=4, overflow pulses once on 5.
//     Then out_ready=1 -> 1,2,3,4 popped in order, fifo_level 4->0.
//  5. IDLE_TIMEOUT=16: 9x4, 16 idle cycles, 9x4 -> two 9s; with only 15 idle cycles -> one 9.
//  6. Edge cases:
//     - clear coincident with a qualifying 4th sample -> no push, fifo_level=0.
//     - rst_n low mid-stream -> all outputs 0 asynchronously; first 7x4 after release -> one 7.

Source files
------------

// File: rtl/asl_result_stabilizer_if.sv
// Handshake bundle between the ASL classifier stream, the stabilizer and the letter consumer.
// The master drives the classification strobe and the out_ready back-pressure; the slave is the stabilizer.
interface asl_result_stabilizer_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             in_valid;
    logic [4:0]       in_label;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       out_label;
    logic [LVL_W-1:0] fifo_level;
    logic             overflow;

    modport master (
        output in_valid, in_label, out_ready,
        input  out_valid, out_label, fifo_level, overflow
    );

    modport slave (
        input  in_valid, in_label, out_ready,
        output out_valid, out_label, fifo_level, overflow
    );
endinterface

// File: rtl/asl_result_stabilizer.sv
// Debounces per-frame ASL labels into single letter events and queues them in a small output FIFO.
// A letter is emitted once per held sign; blanks, an idle timeout or clear re-arm the same letter.
module asl_result_stabilizer #(
    parameter int unsigned NUM_CLASSES  = 26,
    parameter int unsigned STABLE_CNT   = 4,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned IDLE_TIMEOUT = 16000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    asl_result_stabilizer_if.slave  bus
);
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned STR_W  = 4;
    localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    logic [4:0]        cand_q, cand_d;
    logic [STR_W-1:0]  streak_q, streak_d;
    logic [4:0]        last_emit_q, last_emit_d;
    logic              last_vld_q, last_vld_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [4:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;

    logic is_letter, match, qualify, full, pop, push_ok, drop, timeout, out_valid;

    assign is_letter = 32'(bus.in_label) < NUM_CLASSES;
    assign match     = bus.in_label == cand_q;
    assign qualify   = bus.in_valid && is_letter && match
                       && (streak_q == STR_W'(STABLE_CNT - 1))
                       && !(last_vld_q && (last_emit_q == cand_q));
    assign out_valid = count_q != '0;
    assign full      = count_q == LVL_W'(FIFO_DEPTH);
    assign pop       = out_valid && bus.out_ready && !clear;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok   = qualify && (!full || pop) && !clear;
    assign drop      = qualify && full && !pop && !clear;
    assign timeout   = !bus.in_valid && (idle_q == IDLE_W'(IDLE_TIMEOUT - 1));

    // Next-state logic for debounce history, idle timer and FIFO bookkeeping.
    always_comb begin
        cand_d      = cand_q;
        streak_d    = streak_q;
        last_emit_d = last_emit_q;
        last_vld_d  = last_vld_q;
        idle_d      = idle_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ovf_d       = drop;

        if (bus.in_valid) begin
            idle_d = '0;
            if (!is_letter) begin
                streak_d   = '0;
                last_vld_d = 1'b0;
            end else if (match && (streak_q != '0)) begin
                if (streak_q != STR_W'(STABLE_CNT)) streak_d = streak_q + STR_W'(1);
            end else begin
                cand_d   = bus.in_label;
                streak_d = STR_W'(1);
            end
            if (qualify) begin
                last_emit_d = cand_q;
                last_vld_d  = 1'b1;
            end
        end else begin
            if (idle_q != IDLE_W'(IDLE_TIMEOUT)) idle_d = idle_q + IDLE_W'(1);
            if (timeout) begin
                streak_d   = '0;
                last_vld_d = 1'b0;
            end
        end

        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase

        if (clear) begin
            cand_d      = cand_q;
            last_emit_d = last_emit_q;
            streak_d    = '0;
            last_vld_d  = 1'b0;
            idle_d      = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            ovf_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q      <= '0;
            streak_q    <= '0;
            last_emit_q <= '0;
            last_vld_q  <= 1'b0;
            idle_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            cand_q      <= cand_d;
            streak_q    <= streak_d;
            last_emit_q <= last_emit_d;
            last_vld_q  <= last_vld_d;
            idle_q      <= idle_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= cand_q;
        end
    end

    assign bus.out_valid  = out_valid;
    assign bus.out_label  = out_valid ? mem_q[rd_ptr_q] : 5'd0;
    assign bus.fifo_level = count_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_asl_result_stabilizer.sv
// Directed bench for asl_result_stabilizer with a short idle timeout (16 cycles).
module tb_asl_result_stabilizer;
    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    int   n_checks = 0;
    int   n_pass   = 0;

    asl_result_stabilizer_if #(.FIFO_DEPTH(4)) bus ();

    asl_result_stabilizer #(
        .NUM_CLASSES (26),
        .STABLE_CNT  (4),
        .FIFO_DEPTH  (4),
        .IDLE_TIMEOUT(16)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(clear),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic sample(input logic [4:0] lbl);
        bus.in_valid = 1'b1;
        bus.in_label = lbl;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic sample_n(input logic [4:0] lbl, input int n);
        for (int i = 0; i < n; i++) sample(lbl);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_label  = '0;
        bus.out_ready = 1'b1;
        #3;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_label", bus.out_label, 0);
        check("rst_fifo_level", bus.fifo_level, 0);
        check("rst_overflow", bus.overflow, 0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Steady 7: one emission on the 4th sample, none from samples 5-6.
        sample_n(7, 3);
        check("t1_before4_valid", bus.out_valid, 0);
        sample(7);
        check("t1_valid", bus.out_valid, 1);
        check("t1_label", bus.out_label, 7);
        check("t1_level", bus.fifo_level, 1);
        sample(7);
        check("t1_s5_valid", bus.out_valid, 0);
        check("t1_s5_level", bus.fifo_level, 0);
        sample(7);
        check("t1_s6_valid", bus.out_valid, 0);
        clear_pulse();

        // Glitch to 3 restarts the streak.
        sample_n(7, 3);
        sample(3);
        sample_n(7, 3);
        check("t2_s7_valid", bus.out_valid, 0);
        sample(7);
        check("t2_s8_valid", bus.out_valid, 1);
        check("t2_s8_label", bus.out_label, 7);
        clear_pulse();

        // Blank between holds re-arms the same letter.
        sample_n(7, 4);
        check("t3_first_label", bus.out_label, 7);
        sample(31);
        check("t3_blank_valid", bus.out_valid, 0);
        sample_n(7, 3);
        check("t3_second_pre_valid", bus.out_valid, 0);
        sample(7);
        check("t3_second_valid", bus.out_valid, 1);
        check("t3_second_label", bus.out_label, 7);
        clear_pulse();

        // Fill with back-pressure, overflow on the 5th letter, then drain.
        bus.out_ready = 1'b0;
        for (int l = 1; l <= 4; l++) sample_n(5'(l), 4);
        check("t4_full_level", bus.fifo_level, 4);
        check("t4_full_ovf", bus.overflow, 0);
        sample_n(5, 4);
        check("t4_ovf_pulse", bus.overflow, 1);
        check("t4_ovf_level", bus.fifo_level, 4);
        idle(1);
        check("t4_ovf_cleared", bus.overflow, 0);
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("t4_pop_valid", bus.out_valid, 1);
            check("t4_pop_label", bus.out_label, 32'(k));
            idle(1);
            check("t4_pop_level", bus.fifo_level, 32'(4 - k));
        end
        check("t4_empty_valid", bus.out_valid, 0);
        check("t4_empty_label", bus.out_label, 0);
        clear_pulse();

        // Idle timeout of 16 cycles re-arms 9.
        sample_n(9, 4);
        check("t5a_first_label", bus.out_label, 9);
        idle(16);
        check("t5a_idle_level", bus.fifo_level, 0);
        sample_n(9, 4);
        check("t5a_second_valid", bus.out_valid, 1);
        check("t5a_second_label", bus.out_label, 9);
        clear_pulse();

        // 15 idle cycles is one short of the timeout: no second 9.
        sample_n(9, 4);
        check("t5b_first_label", bus.out_label, 9);
        idle(15);
        sample_n(9, 4);
        check("t5b_second_valid", bus.out_valid, 0);
        check("t5b_second_level", bus.fifo_level, 0);
        clear_pulse();

        // Clear coincident with the qualifying sample suppresses the push.
        sample_n(7, 3);
        clear = 1'b1;
        sample(7);
        clear = 1'b0;
        check("t6_clear_level", bus.fifo_level, 0);
        check("t6_clear_valid", bus.out_valid, 0);

        // Asynchronous reset mid-stream, then a fresh 7x4.
        bus.out_ready = 1'b0;
        sample_n(2, 4);
        check("t6_prerst_valid", bus.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", bus.out_valid, 0);
        check("t6_rst_label", bus.out_label, 0);
        check("t6_rst_level", bus.fifo_level, 0);
        check("t6_rst_ovf", bus.overflow, 0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        sample_n(7, 3);
        check("t6_post_pre_valid", bus.out_valid, 0);
        sample(7);
        check("t6_post_valid", bus.out_valid, 1);
        check("t6_post_label", bus.out_label, 7);
        sample(7);
        check("t6_post_level", bus.fifo_level, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
